data_mem_responder: RTL
=======================

# data_mem_responder

Data-memory responder for the five-stage core: the slave end of the memory-stage request interface (`mem_enable`, `mem_r_w`, `mem_address`, `mem_input`). It holds a word-organised data RAM, clears it after reset, services one read or write per cycle, and returns read data after a fixed, parameterised latency with a valid strobe. It also flags illegal accesses and counts traffic for debug.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024, number of 32-bit words; power of two, 16..65536.
- `READ_LATENCY`, 1, cycles from request acceptance to `mem_valid`; legal range 1..3.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_enable`  in  1  request strobe, one request per cycle.
- `mem_r_w`  in  1  1 = write (store), 0 = read (load).
- `mem_address`  in  32  byte address.
- `mem_input`  in  32  write data.
- `mem_output`  out  32  read data; valid only while `mem_valid`=1.
- `mem_valid`  out  1  one-cycle pulse per completed read.
- `mem_err`  out  1  pulses with `mem_valid` for an illegal read, or one cycle after an illegal write.
- `mem_ready`  out  1  1 = initialisation done, requests accepted.
- `err_sticky`  out  1  set by any illegal or dropped access.
- `err_clear`  in  1  clears `err_sticky`; a same-cycle set wins.
- `rd_count`  out  16  accepted legal reads, saturating at 16'hFFFF.
- `wr_count`  out  16  accepted legal writes, saturating at 16'hFFFF.

## Operation
- FSM states: CLEAR and READY.
  - Reset asserted forces CLEAR with clear index = 0.
  - In CLEAR, one word per cycle is written to zero at the clear index, and the index increments.
  - After word `DEPTH_WORDS-1` is written, the FSM goes to READY. READY is held until the next reset.
- `mem_ready` = (state == READY).
- Accepted request: `mem_enable`=1 and `mem_ready`=1.
- Requests while `mem_ready`=0 are dropped: no array access, no `mem_valid`, `err_sticky` set.
- Word index = `mem_address[log2(DEPTH_WORDS)+1:2]`.
- An access is illegal if `mem_address[1:0]` != 0 or `mem_address` >= 4*`DEPTH_WORDS`.
  - Illegal write: the array is unchanged.
  - Illegal read: returns `mem_output` = 0 with `mem_err`=1 alongside `mem_valid`.
  - Either case sets `err_sticky`; counters do not increment.
- Write: the array word is updated at the acceptance edge. Writes produce no `mem_valid`.
- Read: the array is sampled synchronously at the acceptance edge, then delayed through `READ_LATENCY`-1 further register stages carrying data, valid and err.
- Ordering:
  - A write accepted in cycle N is visible to a read accepted in cycle N+1 or later.
  - A write never alters a read already in flight.
- The pipeline is fully pipelined: back-to-back reads give back-to-back `mem_valid` pulses, in order.
- `mem_output` holds its last value when `mem_valid`=0.

## Timing
- Reset values:
  - `mem_output`=0, `mem_valid`=0, `mem_err`=0, `mem_ready`=0, `err_sticky`=0, `rd_count`=0, `wr_count`=0.
  - All pipeline valid bits are 0.
- Reset asserted mid-clear restarts the clear from index 0.
- Reset asserted mid-operation drops every in-flight read: no `mem_valid` follows. RAM contents are re-zeroed.
- Initialisation: with reset released before edge 0, `mem_ready` rises after edge `DEPTH_WORDS`-1, i.e. after `DEPTH_WORDS` clocks.
- Read latency: a request accepted at edge E gives `mem_valid`=1 in the cycle following edge E+`READ_LATENCY`-1.
- Illegal write: the `mem_err` pulse appears one cycle after acceptance, using the same timing as a `READ_LATENCY`=1 read but without `mem_valid`.
- Counter saturation: at 16'hFFFF the counter holds; no wrap.
- `err_clear` and a new error in the same cycle: `err_sticky` stays 1.

## Test plan
- Init: `DEPTH_WORDS`=16, release reset -> `mem_ready`=0 for 16 cycles then 1. A read of address 0x3C returns 0 with `mem_err`=0.
- Write/read: write 0xDEADBEEF to 0x10, read 0x10 the next cycle -> `mem_output`=0xDEADBEEF after `READ_LATENCY` cycles; `wr_count`=1, `rd_count`=1.
- Back-to-back: `READ_LATENCY`=3, reads of 0x0, 0x4, 0x8 on consecutive cycles after writing 1, 2, 3 -> three consecutive `mem_valid` pulses with data 1, 2, 3. Then write 9 to 0x0 the cycle after the last read -> in-flight data is unaffected.
- Illegal accesses:
  - Read 0x11 -> `mem_output`=0, `mem_err`=1, `err_sticky`=1.
  - Write 0x100 with `DEPTH_WORDS`=16 -> no array change; `mem_err` pulses one cycle later.
  - `err_clear` -> `err_sticky`=0.
- Reset mid-flight: issue a read, then assert `reset` before `mem_valid` -> no `mem_valid`, all outputs return to reset values, and the clear restarts; a previously written word reads back 0.
- Drop during init: `mem_enable`=1 while `mem_ready`=0 -> no response, `err_sticky`=1, counters stay 0.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-organised data RAM slave for the memory stage: zero-fills after reset, then one read or write per cycle.
// Reads return after READ_LATENCY cycles, fully pipelined; no backpressure, requests before mem_ready are dropped.
module data_mem_responder #(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_enable,
    input  logic        mem_r_w,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_input,
    output logic [31:0] mem_output,
    output logic        mem_valid,
    output logic        mem_err,
    output logic        mem_ready,
    output logic        err_sticky,
    input  logic        err_clear,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {CLEAR, READY} state_t;

    state_t                           state;
    logic [AW-1:0]                    clr_idx;
    logic [31:0]                      ram [DEPTH_WORDS];
    logic [READ_LATENCY-1:0]          vld_pipe;
    logic [READ_LATENCY-1:0]          err_pipe;
    logic [READ_LATENCY-1:0][31:0]    dat_pipe;
    logic                             wr_err_q;

    logic [AW-1:0] word_idx;
    logic          addr_bad;
    logic          acc_rd;
    logic          acc_wr;
    logic          err_set;

    assign word_idx  = mem_address[AW+1:2];
    assign addr_bad  = (mem_address[1:0] != 2'b00) || (mem_address[31:AW+2] != '0);
    assign mem_ready = (state == READY);
    assign acc_rd    = mem_enable && mem_ready && !mem_r_w;
    assign acc_wr    = mem_enable && mem_ready && mem_r_w;
    assign err_set   = (mem_enable && !mem_ready) || ((acc_rd || acc_wr) && addr_bad);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else if (state == CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == AW'(DEPTH_WORDS - 1))
                state <= READY;
        end
    end

    // The RAM carries no reset; the CLEAR sweep zero-fills it instead.
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            ram[clr_idx] <= '0;
        else if (acc_wr && !addr_bad)
            ram[word_idx] <= mem_input;
    end

    // Data stages only load behind a valid, so the last stage holds between reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            err_pipe <= '0;
            dat_pipe <= '0;
            wr_err_q <= 1'b0;
        end else begin
            vld_pipe[0] <= acc_rd;
            err_pipe[0] <= acc_rd && addr_bad;
            if (acc_rd)
                dat_pipe[0] <= addr_bad ? 32'h0 : ram[word_idx];
            for (int k = 1; k < READ_LATENCY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                err_pipe[k] <= err_pipe[k-1];
                if (vld_pipe[k-1])
                    dat_pipe[k] <= dat_pipe[k-1];
            end
            wr_err_q <= acc_wr && addr_bad;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_sticky <= 1'b0;
            rd_count   <= '0;
            wr_count   <= '0;
        end else begin
            if (err_set)
                err_sticky <= 1'b1;
            else if (err_clear)
                err_sticky <= 1'b0;
            if (acc_rd && !addr_bad && rd_count != 16'hFFFF)
                rd_count <= rd_count + 16'd1;
            if (acc_wr && !addr_bad && wr_count != 16'hFFFF)
                wr_count <= wr_count + 16'd1;
        end
    end

    assign mem_valid  = vld_pipe[READ_LATENCY-1];
    assign mem_output = dat_pipe[READ_LATENCY-1];
    // Illegal-write error always lands one cycle after acceptance, whatever the read latency.
    assign mem_err    = err_pipe[READ_LATENCY-1] || wr_err_q;

endmodule
